// File: rtl/ex_div_stall_unit_if.sv
// +--------------------------------------------------------------------------+
// | Module   : ex_div_stall_unit_if                                          |
// | Purpose  : EX-stage divider bus: operands/control from the pipeline,     |
// |            result/ready and stall request back to the pipeline.          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

interface ex_div_stall_unit_if #(
  parameter int DW      = 32,
  parameter int STALL_W = 6
) ();

  logic [STALL_W-1:0] stall;
  logic               div_start;
  logic               div_signed;
  logic [DW-1:0]      opdata1;
  logic [DW-1:0]      opdata2;
  logic               cancel;
  logic [2*DW-1:0]    div_result;
  logic               div_ready;
  logic               stallreq_for_ex;

  // Pipeline / controller side
  modport master (
    output stall, div_start, div_signed, opdata1, opdata2, cancel,
    input  div_result, div_ready, stallreq_for_ex
  );

  // Divider side
  modport slave (
    input  stall, div_start, div_signed, opdata1, opdata2, cancel,
    output div_result, div_ready, stallreq_for_ex
  );

endinterface

`default_nettype wire

// File: rtl/ex_div_stall_unit.sv
// +--------------------------------------------------------------------------+
// | Module   : ex_div_stall_unit                                             |
// | Purpose  : Iterative radix-2 DIV/DIVU for the EX stage. Raises a stall   |
// |            request while a division is in flight and releases the       |
// |            result once the controller lets EX advance.                   |
// | Options  : DIV_EARLY_OUT_EN - finish at accept when |divisor| exceeds    |
// |            |dividend| (quotient 0, remainder = dividend).                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module ex_div_stall_unit #(
  parameter int DW      = 32,
  parameter int STALL_W = 6,
  parameter int EX_BIT  = 3
) (
  input  wire logic          clk,
  input  wire logic          rst,
  ex_div_stall_unit_if.slave bus
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t            state;
  logic [CW-1:0]     counter;
  logic [2*DW:0]     partial;   // {working remainder (DW+1), quotient/dividend (DW)}
  logic [DW-1:0]     divisor;   // |opdata2|
  logic [DW-1:0]     raw_a;     // dividend exactly as presented
  logic              signed_op;
  logic              sign_a;
  logic              sign_b;
  logic [2*DW-1:0]   result;
  logic              ready;

  logic [DW-1:0]     abs_a;
  logic [DW-1:0]     abs_b;
  logic [2*DW:0]     shifted;
  logic [DW:0]       trial;
  logic [DW:0]       diff;
  logic              ge;
  logic [2*DW:0]     next_partial;
  logic [DW-1:0]     q_raw;
  logic [DW-1:0]     r_raw;
  logic [DW-1:0]     q_fix;
  logic [DW-1:0]     r_fix;
  logic              stall_unused;

  // Operand magnitudes; only DIV takes absolute values
  assign abs_a = (bus.div_signed && bus.opdata1[DW-1]) ? -bus.opdata1 : bus.opdata1;
  assign abs_b = (bus.div_signed && bus.opdata2[DW-1]) ? -bus.opdata2 : bus.opdata2;

  // One restoring shift-subtract step on the partial remainder
  assign shifted      = {partial[2*DW-1:0], 1'b0};
  assign trial        = shifted[2*DW:DW];
  assign diff         = trial - {1'b0, divisor};
  assign ge           = (trial >= {1'b0, divisor});
  assign next_partial = ge ? {diff, shifted[DW-1:1], 1'b1} : shifted;

  // Final-step values with the sign fix-up: quotient sign is the XOR of the
  // operand signs, remainder follows the dividend
  assign q_raw = next_partial[DW-1:0];
  assign r_raw = next_partial[2*DW-1:DW];
  assign q_fix = (signed_op && (sign_a ^ sign_b)) ? -q_raw : q_raw;
  assign r_fix = (signed_op && sign_a) ? -r_raw : r_raw;

  // Only the EX bit of the stall vector matters here
  assign stall_unused = ^bus.stall;

  // Hold EX while a division is outstanding; a flush drops the request at once
  assign bus.stallreq_for_ex = bus.div_start & ~ready & ~bus.cancel;
  assign bus.div_result      = result;
  assign bus.div_ready       = ready;

  // Divider state machine with registered result/ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      counter   <= '0;
      partial   <= '0;
      divisor   <= '0;
      raw_a     <= '0;
      signed_op <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      result    <= '0;
      ready     <= 1'b0;
    end else if (bus.cancel) begin
      state   <= S_IDLE;
      counter <= '0;
      result  <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ready  <= 1'b0;
          result <= '0;
          if (bus.div_start) begin
            signed_op <= bus.div_signed;
            sign_a    <= bus.opdata1[DW-1];
            sign_b    <= bus.opdata2[DW-1];
            raw_a     <= bus.opdata1;
            divisor   <= abs_b;
            partial   <= {{(DW+1){1'b0}}, abs_a};
            counter   <= '0;
            if (bus.opdata2 == '0) begin
              state <= S_DIVZERO;
`ifdef DIV_EARLY_OUT_EN
            end else if (abs_b > abs_a) begin
              state  <= S_END;
              ready  <= 1'b1;
              result <= {bus.opdata1, {DW{1'b0}}};
`endif
            end else begin
              state <= S_ON;
            end
          end
        end

        S_DIVZERO: begin
          if (!bus.div_start) begin
            state <= S_IDLE;
          end else begin
            state  <= S_END;
            ready  <= 1'b1;
            result <= {raw_a, {DW{1'b1}}};
          end
        end

        S_ON: begin
          if (!bus.div_start) begin
            // Instruction left EX without waiting: abandon the division
            state   <= S_IDLE;
            counter <= '0;
          end else begin
            partial <= next_partial;
            counter <= counter + 1'b1;
            if (counter == CW'(DW-1)) begin
              state  <= S_END;
              ready  <= 1'b1;
              result <= {r_fix, q_fix};
            end
          end
        end

        S_END: begin
          // Result stays visible until the controller lets EX advance
          if (!bus.stall[EX_BIT]) begin
            state  <= S_IDLE;
            ready  <= 1'b0;
            result <= '0;
          end
        end

        default: begin
          state <= S_IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_div_stall_unit.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_ex_div_stall_unit                                          |
// | Purpose  : Directed + randomised self-checking bench for the EX divider. |
// |            Honors DIV_EARLY_OUT_EN when defined.                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ex_div_stall_unit;

  localparam int DW      = 32;
  localparam int STALL_W = 6;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ex_div_stall_unit_if #(.DW(DW), .STALL_W(STALL_W)) bus ();

  ex_div_stall_unit #(.DW(DW), .STALL_W(STALL_W), .EX_BIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string       tag;
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: {remainder, quotient}
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (sgn && (a[31] ^ b[31])) q = -q;
    if (sgn && a[31]) r = -r;
    return {r, q};
  endfunction

  function automatic int model_lat(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (mb > ma) return 1;
`endif
    return 33;
  endfunction

  // Called just after a rising edge: that cycle is the accept cycle (0)
  task automatic run_op(input string tag, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    exp_t e;
    int   cyc;
    int   hi;
    bit   got;
    e.tag = tag; e.res = exp_res; e.lat = exp_lat;
    sb.push_back(e);
    bus.div_start  = 1'b1;
    bus.div_signed = sgn;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.cancel     = 1'b0;
    cyc = 0; hi = 0; got = 0;
    @(negedge clk);
    chk({tag, "/ready_at_accept"}, 64'(bus.div_ready), 64'd0);
    while (cyc < 100) begin
      if (bus.div_ready === 1'b1) begin
        got = 1;
        break;
      end
      if (bus.stallreq_for_ex === 1'b1) hi++;
      step();
      cyc++;
      if (cyc == 1) begin
        // Operands must be ignored once accepted
        bus.opdata1    = $urandom;
        bus.opdata2    = $urandom;
        bus.div_signed = ~sgn;
      end
      @(negedge clk);
    end
    chk({tag, "/ready_seen"}, 64'(got), 64'd1);
    e = sb.pop_front();
    if (got) begin
      chk({e.tag, "/latency"}, 64'(cyc), 64'(e.lat));
      chk({e.tag, "/result"}, bus.div_result, e.res);
      chk({e.tag, "/stallreq_at_ready"}, 64'(bus.stallreq_for_ex), 64'd0);
      chk({e.tag, "/stallreq_cycles"}, 64'(hi), 64'(e.lat));
    end
  endtask

  // Instruction leaves EX (stall[3]=0 during the ready cycle); next cycle idle
  task automatic retire(input string tag);
    step();
    bus.div_start = 1'b0;
    @(negedge clk);
    chk({tag, "/ready_after_retire"}, 64'(bus.div_ready), 64'd0);
    chk({tag, "/stallreq_after_retire"}, 64'(bus.stallreq_for_ex), 64'd0);
  endtask

  initial begin
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] held;

    rst            = 1'b1;
    bus.stall      = '0;
    bus.div_start  = 1'b0;
    bus.div_signed = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    bus.cancel     = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("reset/ready", 64'(bus.div_ready), 64'd0);
    chk("reset/result", bus.div_result, 64'd0);
    chk("reset/stallreq", 64'(bus.stallreq_for_ex), 64'd0);
    step();
    rst = 1'b0;

    // Reset in the middle of ON (counter = 10 during cycle 11)
    step();
    bus.div_start = 1'b1; bus.div_signed = 1'b0;
    bus.opdata1 = 32'd100; bus.opdata2 = 32'd7;
    for (int i = 0; i < 11; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.div_start = 1'b0;
    @(negedge clk);
    chk("rst_mid/ready", 64'(bus.div_ready), 64'd0);
    chk("rst_mid/result", bus.div_result, 64'd0);
    chk("rst_mid/stallreq", 64'(bus.stallreq_for_ex), 64'd0);
    for (int i = 0; i < 40; i++) begin
      step();
      @(negedge clk);
      if (i == 39) chk("rst_mid/still_idle", 64'(bus.div_ready), 64'd0);
    end

    // Basic unsigned and signed cases
    step();
    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33);
    retire("divu_100_7");
    step();
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    retire("div_m7_2");
    step();
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
    // Back-to-back: next accept in the cycle after END
    step();
    run_op("divu_b2b", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 33);
    retire("divu_b2b");

    // Divide by zero, then held in END by another stall requester
    step();
    bus.stall = 6'b001000;
    run_op("divu_zero", 1'b0, 32'h1234, 32'h0, {32'h1234, 32'hFFFF_FFFF}, 2);
    held = {32'h1234, 32'hFFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("stall_hold/ready", 64'(bus.div_ready), 64'd1);
      chk("stall_hold/result", bus.div_result, held);
    end
    step();
    bus.stall = '0;
    @(negedge clk);
    chk("stall_release/ready", 64'(bus.div_ready), 64'd1);
    retire("stall_release");

    // Cancel at cycle 12 of ON, new DIVU 9/3 accepted at cycle 13
    step();
    bus.div_start = 1'b1; bus.div_signed = 1'b0;
    bus.opdata1 = 32'd100; bus.opdata2 = 32'd7;
    for (int i = 0; i < 12; i++) step();
    bus.cancel = 1'b1;
    @(negedge clk);
    chk("cancel/stallreq_same_cycle", 64'(bus.stallreq_for_ex), 64'd0);
    step();
    run_op("divu_9_3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 33);
    retire("divu_9_3");

    // Small dividend, large divisor (early-out when enabled)
    step();
    run_op("divu_5_9", 1'b0, 32'd5, 32'd9, {32'h5, 32'h0}, model_lat(1'b0, 32'd5, 32'd9));
    retire("divu_5_9");

    // Randomised mix checked against the reference model
    for (int n = 0; n < 8; n++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (n == 3) b = 32'd0;
      step();
      run_op($sformatf("rand%0d", n), s, a, b, model(s, a, b), model_lat(s, a, b));
      retire($sformatf("rand%0d", n));
    end

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
